// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage types, reset default, instruction field slices and opcodes.
package mips_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_e;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int JTARG_MSB = 25;
  localparam int JTARG_LSB = 0;
  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_ORI  = 6'd13;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;
endpackage

// File: rtl/mips_next_pc.sv
// mips_next_pc: combinational next-PC select (jump > taken branch > sequential).
module mips_next_pc
  import mips_pkg::*;
(
  input  logic [31:0]        pc_plus4,
  input  logic [JTARG_MSB:0] instr_lo,
  input  logic               branch,
  input  logic               jump,
  input  logic               zero,
  output logic [31:0]        next_pc
);
  logic [31:0] br_off;
  always_comb begin
    br_off  = {{14{instr_lo[IMM_MSB]}}, instr_lo[IMM_MSB:IMM_LSB], 2'b00};
    next_pc = jump ? {pc_plus4[31:28], instr_lo[JTARG_MSB:JTARG_LSB], 2'b00}
            : (branch && zero) ? pc_plus4 + br_off
            : pc_plus4;
  end
endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: owns the PC, fetches one word per instruction over req/ack and
// holds it for the decoder until retired.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch,
  input  logic              jump,
  input  logic              zero,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [31:0]       retired_cnt
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, next_pc;
  logic [31:0]       instr_q, instr_d, cnt_q, cnt_d;
  logic              take, retire;
  assign imem_req    = state_q == FETCH;
  assign instr_valid = state_q == ISSUE;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr       = instr_q;
  assign retired_cnt = cnt_q;
  mips_next_pc u_next_pc (
    .pc_plus4 (pc_plus4),
    .instr_lo (instr_q[JTARG_MSB:0]),
    .branch   (branch),
    .jump     (jump),
    .zero     (zero),
    .next_pc  (next_pc)
  );
  always_comb begin
    take    = state_q == FETCH && imem_ack;
    retire  = state_q == ISSUE && instr_ready;
    state_d = state_q == IDLE ? FETCH : take ? ISSUE : retire ? FETCH : state_q;
    instr_d = take ? imem_rdata : instr_q;
    pc_d    = retire ? next_pc : pc_q;
    cnt_d   = cnt_q + {31'd0, retire};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: scoreboard bench; two instances (different RESET_PC) share all inputs.
module tb_mips_fetch_unit;
  logic        clk = 0, rst_n = 0, imem_ack = 0, instr_ready = 0, branch = 0, jump = 0, zero = 0;
  logic [31:0] imem_rdata = 0;
  logic        imem_req, instr_valid, imem_req2, instr_valid2;
  logic [31:0] imem_addr, instr, pc, pc_plus4, retired_cnt;
  logic [31:0] imem_addr2, instr2, pc2, pc_plus42, retired_cnt2;
  int          total = 0, bad = 0;
  logic [31:0] m_pc, m_pc2, m_cnt;
  logic [31:0] exp_q[$], exp2_q[$];
  localparam logic [31:0] RST2 = 32'h4000_0020;
  localparam logic [31:0] ADDI = {6'd8, 5'd1, 5'd1, 16'd5};
  localparam logic [31:0] BEQM = {6'd4, 5'd0, 5'd0, 16'hFFFE};
  localparam logic [31:0] J100 = {6'd2, 26'h100};
  localparam logic [31:0] J004 = {6'd2, 26'h4};

  always #5 clk = ~clk;

  mips_fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch(branch), .jump(jump), .zero(zero), .pc(pc), .pc_plus4(pc_plus4), .retired_cnt(retired_cnt)
  );
  mips_fetch_unit #(.RESET_PC(RST2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr2), .instr_valid(instr_valid2), .instr_ready(instr_ready),
    .branch(branch), .jump(jump), .zero(zero), .pc(pc2), .pc_plus4(pc_plus42), .retired_cnt(retired_cnt2)
  );

  function automatic logic [31:0] model_next(input logic [31:0] p, w, input logic b, j, z);
    logic [31:0] seq, off;
    seq = p + 32'd4;
    off = {{16{w[15]}}, w[15:0]};
    if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (b && z) return seq + off * 32'd4;
    return seq;
  endfunction

  task automatic wait_req(output logic ok);
    ok = 0;
    for (int i = 0; i < 16; i++) begin
      if (imem_req) begin ok = 1; break; end
      @(negedge clk);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL req_timeout imem_req=%b required 1", imem_req); end
  endtask

  task automatic pop_addr();
    logic [31:0] e, e2;
    e = exp_q.pop_front();
    e2 = exp2_q.pop_front();
    total++;
    if (imem_addr !== e || imem_addr2 !== e2) begin
      bad++; $display("FAIL fetch_addr got=%h/%h required=%h/%h", imem_addr, imem_addr2, e, e2);
    end
  endtask

  task automatic apply_reset(input logic ack_in, input logic rdy_in);
    rst_n = 0; imem_ack = ack_in; instr_ready = rdy_in; imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    rst_n = 1; instr_ready = 0; imem_ack = 1;
    total++;
    if ({imem_req, instr_valid, instr, pc, retired_cnt, imem_req2, pc2} !==
        {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, RST2}) begin
      bad++; $display("FAIL reset_vals req=%b valid=%b instr=%h pc=%h cnt=%h pc2=%h required 0/0/0/0/0/%h",
                      imem_req, instr_valid, instr, pc, retired_cnt, pc2, RST2);
    end
    @(negedge clk);
    imem_ack = 0;
    total++;
    if ({imem_req, imem_addr, instr_valid, instr, imem_addr2} !== {1'b1, 32'h0, 1'b0, 32'h0, RST2}) begin
      bad++; $display("FAIL idle_gap req=%b addr=%h valid=%b instr=%h addr2=%h required 1/0/0/0/%h",
                      imem_req, imem_addr, instr_valid, instr, imem_addr2, RST2);
    end
    m_pc = 32'h0; m_pc2 = RST2; m_cnt = 0;
    exp_q.delete(); exp2_q.delete();
  endtask

  task automatic run_instr(input logic [31:0] w, input int ack_dly, input int rdy_dly,
                           input logic b, input logic j, input logic z);
    logic ok;
    logic [31:0] a;
    wait_req(ok);
    if (!ok) return;
    a = imem_addr;
    repeat (ack_dly) begin
      @(negedge clk);
      total++;
      if (imem_req !== 1'b1 || imem_addr !== a) begin
        bad++; $display("FAIL addr_hold req=%b addr=%h required 1/%h", imem_req, imem_addr, a);
      end
    end
    imem_ack = 1; imem_rdata = w;
    @(negedge clk);
    imem_ack = 0; imem_rdata = 32'hDEAD_BEEF;
    total++;
    if ({instr_valid, imem_req, instr, pc, pc_plus4} !== {1'b1, 1'b0, w, m_pc, m_pc + 32'd4}) begin
      bad++; $display("FAIL issue valid=%b req=%b instr=%h pc=%h pc4=%h required 1/0/%h/%h/%h",
                      instr_valid, imem_req, instr, pc, pc_plus4, w, m_pc, m_pc + 32'd4);
    end
    repeat (rdy_dly) begin
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b1 || instr !== w || retired_cnt !== m_cnt) begin
        bad++; $display("FAIL issue_hold valid=%b instr=%h cnt=%0d required 1/%h/%0d",
                        instr_valid, instr, retired_cnt, w, m_cnt);
      end
    end
    instr_ready = 1; branch = b; jump = j; zero = z;
    exp_q.push_back(model_next(m_pc, w, b, j, z));
    exp2_q.push_back(model_next(m_pc2, w, b, j, z));
    m_pc = model_next(m_pc, w, b, j, z);
    m_pc2 = model_next(m_pc2, w, b, j, z);
    m_cnt++;
    @(negedge clk);
    instr_ready = 0; branch = 0; jump = 0; zero = 0;
    total++;
    if (instr_valid !== 1'b0 || retired_cnt !== m_cnt) begin
      bad++; $display("FAIL retire valid=%b cnt=%0d required 0/%0d", instr_valid, retired_cnt, m_cnt);
    end
    wait_req(ok);
    if (ok) pop_addr();
  endtask

  task automatic test_reset();
    apply_reset(1'b0, 1'b0);
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) run_instr(ADDI, 0, 0, 1'b0, 1'b0, 1'b0);
    total++;
    if (retired_cnt !== 32'd3 || imem_addr !== 32'hC) begin
      bad++; $display("FAIL seq_end cnt=%0d addr=%h required 3/0000000c", retired_cnt, imem_addr);
    end
  endtask

  task automatic test_branch();
    run_instr(ADDI, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(BEQM, 0, 0, 1'b1, 1'b0, 1'b1);
    total++;
    if (imem_addr !== 32'hC) begin bad++; $display("FAIL beq_taken addr=%h required 0000000c", imem_addr); end
    run_instr(J004, 0, 0, 1'b0, 1'b1, 1'b0);
    run_instr(BEQM, 0, 0, 1'b1, 1'b0, 1'b0);
    total++;
    if (imem_addr !== 32'h14) begin bad++; $display("FAIL beq_not_taken addr=%h required 00000014", imem_addr); end
  endtask

  task automatic test_jump();
    apply_reset(1'b0, 1'b0);
    run_instr(J100, 0, 0, 1'b0, 1'b1, 1'b0);
    total++;
    if (imem_addr2 !== 32'h4000_0400 || imem_addr !== 32'h400) begin
      bad++; $display("FAIL jump addr=%h addr2=%h required 00000400/40000400", imem_addr, imem_addr2);
    end
    apply_reset(1'b0, 1'b0);
    run_instr(J100, 0, 0, 1'b1, 1'b1, 1'b1);
    total++;
    if (imem_addr2 !== 32'h4000_0400) begin
      bad++; $display("FAIL jump_prio addr2=%h required 40000400", imem_addr2);
    end
  endtask

  task automatic test_wait();
    logic [31:0] c;
    c = retired_cnt;
    run_instr(ADDI, 3, 2, 1'b0, 1'b0, 1'b0);
    total++;
    if (retired_cnt !== c + 32'd1) begin
      bad++; $display("FAIL wait_cnt cnt=%0d required %0d", retired_cnt, c + 32'd1);
    end
  endtask

  task automatic test_wrap();
    apply_reset(1'b0, 1'b0);
    run_instr(BEQM, 0, 0, 1'b1, 1'b0, 1'b1);
    total++;
    if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc addr=%h required fffffffc", imem_addr); end
    run_instr(ADDI, 0, 0, 1'b0, 1'b0, 1'b0);
    total++;
    if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next addr=%h required 00000000", imem_addr); end
  endtask

  task automatic test_reset_fetch();
    apply_reset(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    apply_reset(1'b1, 1'b0);
  endtask

  task automatic test_reset_issue();
    logic ok;
    run_instr(ADDI, 0, 0, 1'b0, 1'b0, 1'b0);
    wait_req(ok);
    imem_ack = 1; imem_rdata = ADDI;
    @(negedge clk);
    imem_ack = 0;
    total++;
    if (instr_valid !== 1'b1 || retired_cnt !== 32'd1) begin
      bad++; $display("FAIL pre_reset_issue valid=%b cnt=%0d required 1/1", instr_valid, retired_cnt);
    end
    apply_reset(1'b0, 1'b1);
    run_instr(ADDI, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_wait();
    test_wrap();
    test_reset_fetch();
    test_reset_issue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
